// File: rtl/store_buffer.sv
// Posted-store FIFO in front of the data memory's shared port: drains one store
// per idle port cycle and forwards buffered bytes into load results.
package store_buffer_pkg;
    typedef enum logic [1:0] {NO_STORE, STORE_BYTE, STORE_WORD, STORE_DWORD} mem_store_type_t;

    typedef struct packed {
        mem_store_type_t typ;
        logic [63:0]     addr;
        logic [63:0]     data;
        logic [7:0]      mask;
        logic [63:0]     lane;
    } sb_entry_t;
endpackage

module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            st_valid,
    input  mem_store_type_t st_type,
    input  logic [63:0]     st_addr,
    input  logic [63:0]     st_data,
    output logic            st_ready,
    input  logic            ld_valid,
    input  logic [63:0]     ld_addr,
    output logic            ld_ready,
    output logic [63:0]     ld_data,
    output logic            empty,
    output logic [63:0]     mem_addr,
    output logic [63:0]     mem_data_in,
    output mem_store_type_t mem_store_type,
    input  logic [63:0]     mem_data_out
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t       ents [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count;
    logic            full, drain, enq;
    sb_entry_t       new_ent;
    logic [2:0]      off;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign st_ready = !full;
    assign ld_ready = !full;
    // A full buffer takes the port even from a pending load so the pipeline can make progress.
    assign drain    = full || (!ld_valid && !empty);
    assign enq      = st_valid && st_ready && (st_type != NO_STORE);

    assign mem_addr       = drain ? ents[head].addr : ld_addr;
    assign mem_store_type = (drain && !reset) ? ents[head].typ : NO_STORE;
    assign mem_data_in    = empty ? 64'd0 : ents[head].data;

    assign off = st_addr[2:0];

    always_comb begin
        new_ent      = '0;
        new_ent.typ  = st_type;
        new_ent.addr = st_addr;
        new_ent.data = st_data;
        case (st_type)
            STORE_BYTE: begin
                new_ent.mask = 8'b1 << off;
                new_ent.lane = {56'd0, st_data[7:0]} << {off, 3'b000};
            end
            STORE_WORD: begin
                if (st_addr[2]) begin
                    new_ent.mask = 8'hf0;
                    new_ent.lane = {st_data[31:0], 32'd0};
                end else begin
                    new_ent.mask = 8'h0f;
                    new_ent.lane = {32'd0, st_data[31:0]};
                end
            end
            STORE_DWORD: begin
                new_ent.mask = 8'hff;
                new_ent.lane = st_data;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (enq)   tail <= tail + 1'b1;
            if (drain) head <= head + 1'b1;
            count <= count + CW'(enq) - CW'(drain);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) ents[tail] <= new_ent;
    end

    // Walk oldest to newest so the youngest store owns each overlapping byte.
    always_comb begin
        logic [PW-1:0] idx;
        ld_data = mem_data_out;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < count && ents[idx].addr[63:3] == ld_addr[63:3]) begin
                for (int b = 0; b < 8; b++) begin
                    if (ents[idx].mask[b]) ld_data[8*b +: 8] = ents[idx].lane[8*b +: 8];
                end
            end
        end
    end

    logic unused_ld_off;
    assign unused_ld_off = ^ld_addr[2:0];
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer with a byte-accurate memory model and a log
// of every write that reaches the memory port.
module tb_store_buffer;
    import store_buffer_pkg::*;

    typedef struct {
        mem_store_type_t t;
        logic [63:0]     a;
        logic [63:0]     d;
    } wr_t;

    logic            clk = 0;
    logic            reset;
    logic            st_valid;
    mem_store_type_t st_type;
    logic [63:0]     st_addr, st_data;
    logic            st_ready;
    logic            ld_valid;
    logic [63:0]     ld_addr;
    logic            ld_ready;
    logic [63:0]     ld_data;
    logic            empty;
    logic [63:0]     mem_addr, mem_data_in, mem_data_out;
    mem_store_type_t mem_store_type;

    logic [63:0] mem [256];
    wr_t         wlog [$];
    int          nvec = 0;
    int          nerr = 0;
    int          base;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_type(st_type), .st_addr(st_addr), .st_data(st_data),
        .st_ready(st_ready),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_ready(ld_ready), .ld_data(ld_data),
        .empty(empty),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_store_type(mem_store_type),
        .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    assign mem_data_out = mem[mem_addr[10:3]];

    always @(negedge clk) begin
        if (mem_store_type != NO_STORE) begin
            case (mem_store_type)
                STORE_BYTE:  mem[mem_addr[10:3]][8*mem_addr[2:0] +: 8] <= mem_data_in[7:0];
                STORE_WORD:  if (mem_addr[2]) mem[mem_addr[10:3]][63:32] <= mem_data_in[31:0];
                             else             mem[mem_addr[10:3]][31:0]  <= mem_data_in[31:0];
                default:     mem[mem_addr[10:3]] <= mem_data_in;
            endcase
            wlog.push_back('{mem_store_type, mem_addr, mem_data_in});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input mem_store_type_t t, input logic [63:0] a, input logic [63:0] d);
        st_valid = 1; st_type = t; st_addr = a; st_data = d;
    endtask

    task automatic chk_log(input string tag, input int i, input mem_store_type_t t,
                           input logic [63:0] a, input logic [63:0] d);
        if (i < wlog.size()) begin
            chk({tag, "_type"}, 64'(wlog[i].t), 64'(t));
            chk({tag, "_addr"}, wlog[i].a, a);
            chk({tag, "_data"}, wlog[i].d, d);
        end else begin
            chk({tag, "_present"}, 64'(wlog.size()), 64'(i + 1));
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        reset = 1; st_valid = 0; st_type = NO_STORE; st_addr = 0; st_data = 0;
        ld_valid = 0; ld_addr = 0;
        #2;
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_mem_type", 64'(mem_store_type), 64'(NO_STORE));
        chk("rst_ld_ready", 64'(ld_ready), 64'd1);
        chk("rst_ld_data", ld_data, 64'd0);
        chk("rst_mem_data_in", mem_data_in, 64'd0);
        tick();
        reset = 0;

        // Single dword store drains on the following cycle
        tick();
        put(STORE_DWORD, 64'h100, 64'h1122334455667788);
        #1 chk("t1_empty_pre", 64'(empty), 64'd1);
        tick();
        st_valid = 0;
        #1;
        chk("t1_drain_type", 64'(mem_store_type), 64'(STORE_DWORD));
        chk("t1_drain_addr", mem_addr, 64'h100);
        chk("t1_drain_data", mem_data_in, 64'h1122334455667788);
        tick();
        chk("t1_empty_post", 64'(empty), 64'd1);
        ld_valid = 1; ld_addr = 64'h100;
        #1 chk("t1_mem_readback", ld_data, 64'h1122334455667788);

        // Load stalls drain; byte + word forwarded into one dword
        ld_addr = 64'h200;
        put(STORE_BYTE, 64'h203, 64'hAB);
        tick();
        put(STORE_WORD, 64'h204, 64'hDEADBEEF);
        #1 chk("t2_fwd_byte_only", ld_data, 64'h00000000_AB000000);
        tick();
        st_valid = 0;
        #1;
        chk("t2_fwd_merge", ld_data, 64'hDEADBEEF_AB000000);
        chk("t2_ld_ready", 64'(ld_ready), 64'd1);
        chk("t2_stall_type", 64'(mem_store_type), 64'(NO_STORE));
        base = wlog.size();
        ld_valid = 0;
        tick(); tick();
        chk_log("t2_w0", base, STORE_BYTE, 64'h203, 64'hAB);
        chk_log("t2_w1", base + 1, STORE_WORD, 64'h204, 64'hDEADBEEF);
        ld_valid = 1;
        #1 chk("t2_mem_merge", ld_data, 64'hDEADBEEF_AB000000);

        // Overlapping bytes: newest wins, drained in program order
        ld_addr = 64'h208;
        put(STORE_BYTE, 64'h208, 64'h11);
        tick();
        put(STORE_BYTE, 64'h208, 64'h22);
        tick();
        st_valid = 0;
        #1 chk("t3_newest_wins", ld_data, 64'h22);
        base = wlog.size();
        ld_valid = 0;
        tick(); tick(); tick();
        chk_log("t3_w0", base, STORE_BYTE, 64'h208, 64'h11);
        chk_log("t3_w1", base + 1, STORE_BYTE, 64'h208, 64'h22);

        // Fill to DEPTH with the load held: drain takes over, then load regains the port
        ld_valid = 1; ld_addr = 64'h300;
        base = wlog.size();
        for (int k = 0; k < 4; k++) begin
            put(STORE_DWORD, 64'h300 + 64'(8 * k), 64'(k + 1));
            tick();
        end
        put(STORE_DWORD, 64'h320, 64'd5);
        #1;
        chk("t4_full_st_ready", 64'(st_ready), 64'd0);
        chk("t4_full_ld_ready", 64'(ld_ready), 64'd0);
        chk("t4_full_type", 64'(mem_store_type), 64'(STORE_DWORD));
        chk("t4_full_addr", mem_addr, 64'h300);
        tick();
        st_valid = 0;
        #1;
        chk("t4_st_ready_back", 64'(st_ready), 64'd1);
        chk("t4_ld_ready_back", 64'(ld_ready), 64'd1);
        chk("t4_ld_data", ld_data, 64'd1);
        ld_valid = 0;
        tick(); tick(); tick();
        chk("t4_empty", 64'(empty), 64'd1);
        chk("t4_nwrites", 64'(wlog.size() - base), 64'd4);
        for (int k = 0; k < 4; k++)
            chk_log("t4_w", base + k, STORE_DWORD, 64'h300 + 64'(8 * k), 64'(k + 1));

        // Back-to-back stores with no loads wrap the pointers and never build up
        base = wlog.size();
        for (int k = 0; k < 10; k++) begin
            put(STORE_DWORD, 64'h400 + 64'(8 * k), 64'hA0 + 64'(k));
            tick();
            chk("t5_single_entry", mem_addr, 64'h400 + 64'(8 * k));
        end
        st_valid = 0;
        tick();
        chk("t5_empty", 64'(empty), 64'd1);
        for (int k = 0; k < 10; k++)
            chk_log("t5_w", base + k, STORE_DWORD, 64'h400 + 64'(8 * k), 64'hA0 + 64'(k));

        // Reset with entries pending aborts the in-flight write
        ld_valid = 1; ld_addr = 64'h600;
        for (int k = 0; k < 3; k++) begin
            put(STORE_DWORD, 64'h500 + 64'(8 * k), 64'hF0 + 64'(k));
            tick();
        end
        st_valid = 0; ld_valid = 0;
        #1 chk("t6_draining", 64'(mem_store_type), 64'(STORE_DWORD));
        base = wlog.size();
        reset = 1;
        #1;
        chk("t6_rst_type", 64'(mem_store_type), 64'(NO_STORE));
        chk("t6_rst_empty", 64'(empty), 64'd1);
        chk("t6_rst_mem_data_in", mem_data_in, 64'd0);
        tick();
        reset = 0;
        tick(); tick();
        chk("t6_no_writes", 64'(wlog.size() - base), 64'd0);
        ld_valid = 1; ld_addr = 64'h500;
        #1 chk("t6_mem_untouched", ld_data, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/store_buffer.md
# store_buffer

Posted-store FIFO between the MEM pipeline stage and the data memory's single shared address/write port. Accepts stores from the pipeline and drains them to memory one per cycle when no load is using the port. Forwards buffered bytes into load results so loads always see program-order-correct data. Lets the MEM stage retire stores without waiting on the port.

## Interface
- DEPTH, 4: number of store entries; power of two, 2..16.
- clk  in  1  pipeline clock; state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- st_valid  in  1  store request from MEM stage.
- st_type  in  mem_store_type_t  NO_STORE / STORE_BYTE / STORE_WORD / STORE_DWORD.
- st_addr  in  64  store byte address.
- st_data  in  64  store data, unaligned (LSB-justified, as for the memory's data_in).
- st_ready  out  1  store can be accepted this cycle.
- ld_valid  in  1  load request from MEM stage.
- ld_addr  in  64  load byte address.
- ld_ready  out  1  load is granted the memory port this cycle.
- ld_data  out  64  dword at ld_addr[63:3] with buffered bytes merged in.
- empty  out  1  no entries pending (used for syscall/halt fencing).
- mem_addr  out  64  to memory addr.
- mem_data_in  out  64  to memory data_in.
- mem_store_type  out  mem_store_type_t  to memory mem_store_type.
- mem_data_out  in  64  from memory data_out (combinational read of dword at mem_addr).

## Operation
- Entry fields: type, addr, raw data, 8-bit byte mask, 64-bit lane-aligned data.
- Mask/lane rules at enqueue, off = st_addr[2:0]: BYTE: mask = 1<<off, lane = (st_data & 0xff) << 8*off. WORD: st_addr[2]=0 -> mask 0x0f, lane[31:0] = st_data[31:0]; st_addr[2]=1 -> mask 0xf0, lane[63:32] = st_data[31:0]. DWORD: mask 0xff, lane = st_data. Other lanes zero.
- Enqueue: st_valid && st_ready && st_type != NO_STORE writes entry at tail, tail++. st_valid with NO_STORE is dropped silently.
- st_ready = (count < DEPTH). No same-cycle full-bypass: a full buffer refuses even if it drains that cycle.
- Port arbitration (combinational):
  - count == DEPTH: drain wins, ld_ready = 0.
  - Else ld_valid: load wins, ld_ready = 1, mem_addr = ld_addr, mem_store_type = NO_STORE.
  - Else count > 0: drain.
  - Else idle: mem_addr = ld_addr, NO_STORE.
- Drain: mem_addr = head.addr, mem_data_in = head.data, mem_store_type = head.type. The memory writes at the negedge of that cycle; head++ at the following posedge.
- mem_data_in = head raw data whenever count > 0, else 0.
- Forwarding: ld_data starts from mem_data_out. Each valid entry whose addr[63:3] == ld_addr[63:3] is overlaid byte-wise under its mask, oldest to newest, so the newest store wins per byte. Forwarding covers registered entries only; a store enqueued in the same cycle is not visible.
- Simultaneous enqueue and drain: count unchanged, both pointers advance.
- Pointer wrap modulo DEPTH; count is a separate $clog2(DEPTH)+1-bit register.
- empty = (count == 0).

## Timing
- Reset (async, immediate): head = tail = count = 0; all entries are discarded, and the memory reloads its image anyway.
- Output values during and after reset: st_ready = 1, empty = 1, mem_store_type = NO_STORE, ld_ready = 1, ld_data = mem_data_out, mem_data_in = 0.
- Store latency: accepted at posedge N, earliest memory write at negedge of cycle N+1 if no load contends.
- Load latency: 0 cycles, combinational through the memory's data_out.
- Deassertion of reset mid-drain: the aborted write does not occur because mem_store_type is forced to NO_STORE while reset is high.
- Steady one-store-per-cycle drain throughput with no loads.

## Test plan
- Reset, then STORE_DWORD addr 0x100 data 0x1122334455667788, no loads -> drained next cycle with mem_store_type = STORE_DWORD and mem_addr = 0x100; empty = 1 after the following posedge.
- Stall drain with ld_valid to ld_addr 0x200. Buffer STORE_BYTE 0x203 data 0xAB, then STORE_WORD 0x204 data 0xDEADBEEF, with mem_data_out = 0. Load 0x200 -> ld_data = 0xDEADBEEF_AB000000.
- Overlapping stores: STORE_BYTE 0x208 data 0x11, then STORE_BYTE 0x208 data 0x22, then load 0x208 -> byte 0 = 0x22 (newest wins). Drain order to memory is 0x11 then 0x22.
- Fill DEPTH=4 while ld_valid is held high -> st_ready = 0 and ld_ready = 0 on the next cycle. The head drains, st_ready rises after that posedge, and ld_ready is regained.
- Wrap: 10 stores back-to-back, no loads -> all 10 appear on the memory port in order, and count never exceeds 1.
- Assert reset with 3 entries pending -> mem_store_type goes NO_STORE immediately, and empty = 1. No further writes appear after release.
